uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester message arbiter feeding a byte-level UART
// transmitter. A granted message is latched whole into an internal buffer
// and streamed byte 0 first, one tx_start per byte, pacing on tx_busy.
// After each message the block idles in GAP before it samples requests again.
//
// Optional feature: define UART_ARB_ROUNDROBIN_EN to alternate the winner on
// simultaneous requests. Without it requester 0 always wins a tie.
//
// Handshakes: reqX is a level held by the requester until gntX pulses. gntX
// means msgX has been captured, so the requester may drop req and change msg.
// tx_start is a one-cycle pulse with tx_data valid in that cycle; it is only
// issued after tx_busy has been sampled low. doneX pulses once the last byte
// of requester X's message has left the transmitter.
module uart_tx_arbiter #(
   parameter int MSG_LEN    = 11,
   parameter int GAP_CYCLES = 0
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   req0,
   input  logic [8*MSG_LEN-1:0]   msg0,
   input  logic                   req1,
   input  logic [8*MSG_LEN-1:0]   msg1,
   output logic                   gnt0,
   output logic                   gnt1,
   output logic                   done0,
   output logic                   done1,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic [2:0]             o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEND  = 3'd1,
      ST_WAIT1 = 3'd2,
      ST_WAIT  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam logic [7:0] LP_LAST = 8'(MSG_LEN - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [8*MSG_LEN-1:0] r_buf;
   logic [7:0]           r_idx;
   logic [15:0]          r_gap_cnt;
   logic                 r_owner;
   logic                 r_gnt0;
   logic                 r_gnt1;
   logic                 r_done0;
   logic                 r_done1;
   logic                 r_tx_start;
   logic [7:0]           r_tx_data;
`ifdef UART_ARB_ROUNDROBIN_EN
   logic                 r_last_gnt;
`endif

   logic                 w_any_req;
   logic                 w_pick1;
   logic                 w_last_byte;
   logic                 w_gap_last;
   logic [7:0]           w_cur_byte;
   logic                 w_grant;
   logic                 w_gnt0_nxt;
   logic                 w_gnt1_nxt;
   logic                 w_done0_nxt;
   logic                 w_done1_nxt;
   logic                 w_tx_start_nxt;
   logic [7:0]           w_tx_data_nxt;
   logic                 w_idx_inc;
   logic                 w_gap_clr;
   logic                 w_gap_inc;

   assign w_any_req   = req0 | req1;
   assign w_last_byte = (r_idx == LP_LAST);
   // GAP lasts GAP_CYCLES cycles, with a floor of one cycle when it is zero
   assign w_gap_last  = (({1'b0, r_gap_cnt} + 17'd1) >= 17'(GAP_CYCLES));

   // Tie-break between requesters; a lone request always wins
`ifdef UART_ARB_ROUNDROBIN_EN
   assign w_pick1 = req1 & (~req0 | ~r_last_gnt);
`else
   assign w_pick1 = req1 & ~req0;
`endif

   // Select the buffered byte addressed by the current index
   always_comb begin
      w_cur_byte = 8'h00;
      for (int k = 0; k < MSG_LEN; k++) begin
         if (r_idx == 8'(k)) begin
            w_cur_byte = r_buf[8*k +: 8];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_any_req) w_state_nxt = ST_SEND;
         ST_SEND:  if (!tx_busy) w_state_nxt = ST_WAIT1;
         ST_WAIT1: w_state_nxt = ST_WAIT;
         ST_WAIT:  if (!tx_busy) w_state_nxt = w_last_byte ? ST_GAP : ST_SEND;
         ST_GAP:   if (w_gap_last) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Output and datapath control decoded from the current state
   always_comb begin
      w_grant        = 1'b0;
      w_gnt0_nxt     = 1'b0;
      w_gnt1_nxt     = 1'b0;
      w_done0_nxt    = 1'b0;
      w_done1_nxt    = 1'b0;
      w_tx_start_nxt = 1'b0;
      w_tx_data_nxt  = r_tx_data;
      w_idx_inc      = 1'b0;
      w_gap_clr      = 1'b0;
      w_gap_inc      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_grant    = 1'b1;
               w_gnt0_nxt = ~w_pick1;
               w_gnt1_nxt = w_pick1;
            end
         end
         ST_SEND: begin
            if (!tx_busy) begin
               w_tx_start_nxt = 1'b1;
               w_tx_data_nxt  = w_cur_byte;
            end
         end
         ST_WAIT: begin
            if (!tx_busy) begin
               if (w_last_byte) begin
                  w_done0_nxt = ~r_owner;
                  w_done1_nxt = r_owner;
                  w_gap_clr   = 1'b1;
               end else begin
                  w_idx_inc = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (w_gap_last) begin
               w_gap_clr = 1'b1;
            end else begin
               w_gap_inc = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_done0    <= 1'b0;
         r_done1    <= 1'b0;
         r_tx_start <= 1'b0;
         r_tx_data  <= 8'h00;
      end else begin
         r_gnt0     <= w_gnt0_nxt;
         r_gnt1     <= w_gnt1_nxt;
         r_done0    <= w_done0_nxt;
         r_done1    <= w_done1_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_tx_data  <= w_tx_data_nxt;
      end
   end

   // Message buffer, byte index, owner and gap counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_buf     <= '0;
         r_idx     <= 8'd0;
         r_owner   <= 1'b0;
         r_gap_cnt <= 16'd0;
      end else begin
         if (w_grant) begin
            r_buf   <= w_pick1 ? msg1 : msg0;
            r_owner <= w_pick1;
            r_idx   <= 8'd0;
         end else if (w_idx_inc) begin
            r_idx <= r_idx + 8'd1;
         end
         if (w_gap_clr) begin
            r_gap_cnt <= 16'd0;
         end else if (w_gap_inc) begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
         end
      end
   end

`ifdef UART_ARB_ROUNDROBIN_EN
   // Remember who was granted last; reset favours requester 0 next
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last_gnt <= 1'b1;
      end else if (w_grant) begin
         r_last_gnt <= w_pick1;
      end
   end
`endif

   assign gnt0        = r_gnt0;
   assign gnt1        = r_gnt1;
   assign done0       = r_done0;
   assign done1       = r_done1;
   assign tx_start    = r_tx_start;
   assign tx_data     = r_tx_data;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: MSG_LEN 11, GAP_CYCLES 5, transmitter model that
// raises tx_busy the cycle after tx_start and holds it for 10 cycles.
// Expected cycle offsets and bytes are written out by hand below.
module tb_uart_tx_arbiter;

   localparam int MSG_LEN  = 11;
   localparam int GAP      = 5;
   localparam int BUSY_LEN = 10;

   // clock / reset
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic                 req0, req1;
   logic [8*MSG_LEN-1:0] msg0, msg1;
   logic                 gnt0, gnt1, done0, done1;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_busy;
   logic [2:0]           o_dbg_state;

   uart_tx_arbiter #(.MSG_LEN(MSG_LEN), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rstn(rstn),
      .req0(req0), .msg0(msg0), .req1(req1), .msg1(msg1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .o_dbg_state(o_dbg_state)
   );

   // "Value: 101\n" and "Hello,arb!\r", byte 0 first
   logic [7:0] val_bytes [MSG_LEN] = '{8'h56, 8'h61, 8'h6C, 8'h75, 8'h65, 8'h3A,
                                       8'h20, 8'h31, 8'h30, 8'h31, 8'h0A};
   logic [7:0] hel_bytes [MSG_LEN] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C,
                                       8'h61, 8'h72, 8'h62, 8'h21, 8'h0D};

   // scoreboard / logs
   int n_chk = 0;
   int n_pass = 0;
   int cyc;
   int busy_cnt;
   bit busy_pend;
   bit stall;
   int req0_rem, req1_rem;
   int n_viol = 0;
   int n_clash = 0;
   int rx_q[$];
   int start_cyc_q[$];
   int gnt_q[$];
   int gnt0_cyc_q[$], gnt1_cyc_q[$];
   int done0_cyc_q[$], done1_cyc_q[$];

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   function automatic logic [8*MSG_LEN-1:0] pack_msg(input logic [7:0] b [MSG_LEN]);
      logic [8*MSG_LEN-1:0] m;
      for (int k = 0; k < MSG_LEN; k++) m[8*k +: 8] = b[k];
      return m;
   endfunction

   // transmitter model and output monitor, 1 time unit after each edge
   initial begin
      cyc = 0; busy_cnt = 0; busy_pend = 0; tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (tx_start && tx_busy) n_viol++;
         if (busy_pend) begin
            busy_cnt  = BUSY_LEN;
            busy_pend = 0;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
         tx_busy = (busy_cnt > 0) || stall;
         if (tx_start) begin
            rx_q.push_back(int'(tx_data));
            start_cyc_q.push_back(cyc);
            busy_pend = 1;
         end
         if (gnt0) begin
            gnt_q.push_back(0); gnt0_cyc_q.push_back(cyc);
            if (req0_rem > 0) req0_rem--;
            req0 = (req0_rem > 0);
         end
         if (gnt1) begin
            gnt_q.push_back(1); gnt1_cyc_q.push_back(cyc);
            if (req1_rem > 0) req1_rem--;
            req1 = (req1_rem > 0);
         end
         if (done0) done0_cyc_q.push_back(cyc);
         if (done1) done1_cyc_q.push_back(cyc);
         if ((gnt0 && gnt1) || (done0 && done1) || (gnt0 && done1) || (gnt1 && done0)) n_clash++;
      end
   end

   // driver tasks: stimulus changes 3 time units after an edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic clr_log();
      rx_q.delete(); start_cyc_q.delete(); gnt_q.delete();
      gnt0_cyc_q.delete(); gnt1_cyc_q.delete();
      done0_cyc_q.delete(); done1_cyc_q.delete();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req0 = 1'b0; req1 = 1'b0; req0_rem = 0; req1_rem = 0; stall = 0;
      tick(15);
      rstn = 1'b1;
      tick(1);
      clr_log();
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      int k = 0;
      while (!(req0 == 1'b0 && req1 == 1'b0 && o_dbg_state == 3'd0 && tx_busy == 1'b0) && k < budget) begin
         tick(1);
         k++;
      end
      check({tag, "_timeout"}, int'(k >= budget), 0);
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] b [MSG_LEN]);
      check({tag, "_nbytes"}, rx_q.size(), MSG_LEN);
      for (int k = 0; k < MSG_LEN; k++) begin
         check($sformatf("%s_byte%0d", tag, k), qget(rx_q, k), int'(b[k]));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int t_req;
      int r_cyc;
      int n_win;
      int exp_seq [4];
      rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; msg0 = '0; msg1 = '0;
      stall = 0; req0_rem = 0; req1_rem = 0;

      // reset state
      tick(2);
      check("rst_tx_data", int'(tx_data), 0);
      check("rst_tx_start", int'(tx_start), 0);
      check("rst_gnt0", int'(gnt0), 0);
      check("rst_gnt1", int'(gnt1), 0);
      check("rst_done0", int'(done0), 0);
      check("rst_done1", int'(done1), 0);
      check("rst_state", int'(o_dbg_state), 0);
      do_reset();

      // single message: gnt next cycle, tx_start the cycle after, 13-cycle byte pitch
      msg0 = pack_msg(val_bytes);
      req0_rem = 1; req0 = 1'b1; t_req = cyc;
      wait_quiet("single", 400);
      check("single_ngnt0", gnt0_cyc_q.size(), 1);
      check("single_ngnt1", gnt1_cyc_q.size(), 0);
      check("single_gnt_lat", qget(gnt0_cyc_q, 0) - t_req, 1);
      check("single_start_lat", qget(start_cyc_q, 0) - t_req, 2);
      check("single_pitch", qget(start_cyc_q, 1) - qget(start_cyc_q, 0), 13);
      check("single_ndone0", done0_cyc_q.size(), 1);
      check("single_done_lat", qget(done0_cyc_q, 0) - qget(start_cyc_q, MSG_LEN - 1), 12);
      check_bytes("single", val_bytes);

      // contention: both requests raised together and held
      do_reset();
      msg1 = pack_msg(hel_bytes);
`ifdef UART_ARB_ROUNDROBIN_EN
      req0_rem = 2; req1_rem = 2;
      exp_seq = '{0, 1, 0, 1};
`else
      req0_rem = 3; req1_rem = 1;
      exp_seq = '{0, 0, 0, 1};
`endif
      req0 = 1'b1; req1 = 1'b1;
      wait_quiet("contend", 1500);
      check("contend_ngnt", gnt_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("contend_gnt%0d", k), qget(gnt_q, k), exp_seq[k]);
      end
      check("contend_nstart", start_cyc_q.size(), 4 * MSG_LEN);
      check("contend_ndone", done0_cyc_q.size() + done1_cyc_q.size(), 4);

      // gap: back-to-back req0, done0 to next gnt0 = GAP + 1, no tx_start between
      do_reset();
      req0_rem = 2; req0 = 1'b1;
      wait_quiet("gap", 800);
      check("gap_ngnt0", gnt0_cyc_q.size(), 2);
      check("gap_ndone0", done0_cyc_q.size(), 2);
      check("gap_spacing", qget(gnt0_cyc_q, 1) - qget(done0_cyc_q, 0), GAP + 1);
      n_win = 0;
      foreach (start_cyc_q[i]) begin
         if (start_cyc_q[i] > qget(done0_cyc_q, 0) && start_cyc_q[i] <= qget(gnt0_cyc_q, 1)) n_win++;
      end
      check("gap_no_start", n_win, 0);
      check("gap_nstart", start_cyc_q.size(), 2 * MSG_LEN);

      // busy stall: tx_busy forced high from SEND entry for 50 cycles
      do_reset();
      stall = 1; req0_rem = 1; req0 = 1'b1;
      tick(1);
      tick(50);
      check("stall_no_start", start_cyc_q.size(), 0);
      r_cyc = cyc;
      stall = 0;
      wait_quiet("stall", 400);
      check("stall_release", qget(start_cyc_q, 0) - r_cyc, 2);
      check("stall_ndone0", done0_cyc_q.size(), 1);
      check("stall_nstart", start_cyc_q.size(), MSG_LEN);

      // reset mid-message: after 4 bytes, with req1 pending
      do_reset();
      msg0 = pack_msg(val_bytes);
      msg1 = pack_msg(hel_bytes);
      req0_rem = 1; req0 = 1'b1;
      begin
         int k = 0;
         while (rx_q.size() < 4 && k < 300) begin
            tick(1);
            k++;
         end
         check("midrst_reach_timeout", int'(k >= 300), 0);
      end
      req1_rem = 1; req1 = 1'b1;
      #2;
      rstn = 1'b0; req0 = 1'b0; req0_rem = 0;
      #1;
      check("midrst_tx_data", int'(tx_data), 0);
      check("midrst_tx_start", int'(tx_start), 0);
      check("midrst_gnt", int'(gnt0) + int'(gnt1), 0);
      check("midrst_done", int'(done0) + int'(done1), 0);
      check("midrst_state", int'(o_dbg_state), 0);
      tick(15);
      check("midrst_ndone0", done0_cyc_q.size(), 0);
      clr_log();
      rstn = 1'b1;
      wait_quiet("midrst", 400);
      check("midrst_ngnt", gnt_q.size(), 1);
      check("midrst_first_gnt", qget(gnt_q, 0), 1);
      check("midrst_ndone1", done1_cyc_q.size(), 1);
      check("midrst_post_done0", done0_cyc_q.size(), 0);
      check_bytes("midrst", hel_bytes);

      // request drop: req1 pulsed during message 0, never granted
      do_reset();
      req0_rem = 1; req0 = 1'b1;
      tick(20);
      req1 = 1'b1;
      tick(5);
      req1 = 1'b0;
      wait_quiet("drop", 400);
      tick(10);
      check("drop_ngnt1", gnt1_cyc_q.size(), 0);
      check("drop_ndone0", done0_cyc_q.size(), 1);
      check("drop_state", int'(o_dbg_state), 0);

      check("proto_start_while_busy", n_viol, 0);
      check("pulse_clash", n_clash, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
